// File: rtl/altsyncram_arbiter.sv
// Two-requester arbiter and clear-on-reset sequencer for one altsyncram port.
// After reset (or an init_req pulse) every word is overwritten with INIT_VALUE.
// Then the port is shared round-robin between two valid/ready requesters, and
// read data is steered back to the issuer through a tag pipeline whose depth
// matches the RAM read latency.
module altsyncram_arbiter #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned           RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock0,
  input  logic                  aclr_n,
  input  logic                  init_req,
  output logic                  init_done,
  // Requester 0
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_adr,
  input  logic [BE_WIDTH-1:0]   req0_be,
  input  logic [DATA_WIDTH-1:0] req0_d,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_q,
  // Requester 1
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_adr,
  input  logic [BE_WIDTH-1:0]   req1_be,
  input  logic [DATA_WIDTH-1:0] req1_d,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_q,
  // RAM port A
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [BE_WIDTH-1:0]   mem_byteena,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  // Only the two altsyncram output-register settings are meaningful.
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : gen_bad_latency
    $error("altsyncram_arbiter: RD_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0 || BE_WIDTH != DATA_WIDTH / 8) begin : gen_bad_width
    $error("altsyncram_arbiter: DATA_WIDTH must be a multiple of 8 with one BE per byte");
  end

  // Keeps vector sizes legal even when the latency check above fires.
  localparam int unsigned TagDepth = (RD_LATENCY < 1) ? 1 : RD_LATENCY;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  prio_q, prio_d;
  logic [TagDepth-1:0]   tag_vld_q, tag_vld_d;
  logic [TagDepth-1:0]   tag_id_q, tag_id_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [BE_WIDTH-1:0]   be_hold_q;
  logic [DATA_WIDTH-1:0] data_hold_q;

  logic                  gnt0, gnt1, conflict;
  logic                  rd_hs;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [BE_WIDTH-1:0]   be_c;
  logic [DATA_WIDTH-1:0] data_c;
  logic                  wren_c, rden_c;

  // Grant: a lone requester always wins; on a conflict prio picks the winner.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    conflict = 1'b0;
    if (state_q == StRun) begin
      if (req0_valid && req1_valid) begin
        conflict = 1'b1;
        gnt0     = ~prio_q;
        gnt1     = prio_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  // Priority passes to the loser of each conflict, i.e. flips on every conflict.
  always_comb begin
    prio_d = prio_q;
    if (conflict) begin
      prio_d = ~prio_q;
    end
  end

  // Sequencer next state: walk the clear counter, then hand the port to the requesters.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StInit: begin
        if (init_req) begin
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
          if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (init_req) begin
          state_d   = StInit;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = StInit;
        clr_cnt_d = '0;
      end
    endcase
  end

  // RAM port mux: clear writes in INIT, the granted requester in RUN, else hold.
  always_comb begin
    addr_c = addr_hold_q;
    be_c   = be_hold_q;
    data_c = data_hold_q;
    wren_c = 1'b0;
    rden_c = 1'b0;
    if (state_q == StInit) begin
      addr_c = clr_cnt_q;
      be_c   = {BE_WIDTH{1'b1}};
      data_c = INIT_VALUE;
      wren_c = 1'b1;
    end else if (gnt0) begin
      addr_c = req0_adr;
      be_c   = req0_be;
      data_c = req0_d;
      wren_c = req0_we;
      rden_c = ~req0_we;
    end else if (gnt1) begin
      addr_c = req1_adr;
      be_c   = req1_be;
      data_c = req1_d;
      wren_c = req1_we;
      rden_c = ~req1_we;
    end
  end

  // Tag pipeline next state: stage 0 captures the read handshake, later stages shift.
  always_comb begin
    rd_hs       = (gnt0 && !req0_we) || (gnt1 && !req1_we);
    tag_vld_d   = tag_vld_q;
    tag_id_d    = tag_id_q;
    tag_vld_d[0] = rd_hs;
    tag_id_d[0]  = gnt1;
    for (int k = 1; k < TagDepth; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  // State, arbitration and tag registers.
  always_ff @(posedge clock0 or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= StInit;
      clr_cnt_q <= '0;
      prio_q    <= 1'b0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      prio_q    <= prio_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  // Remember the last address/data driven so idle cycles do not toggle the RAM bus.
  always_ff @(posedge clock0 or negedge aclr_n) begin
    if (!aclr_n) begin
      addr_hold_q <= '0;
      be_hold_q   <= '0;
      data_hold_q <= '0;
    end else begin
      addr_hold_q <= addr_c;
      be_hold_q   <= be_c;
      data_hold_q <= data_c;
    end
  end

  // Outputs; the RAM bus is forced quiet while reset is held.
  always_comb begin
    mem_address = aclr_n ? addr_c : '0;
    mem_byteena = aclr_n ? be_c : '0;
    mem_data    = aclr_n ? data_c : '0;
    mem_wren    = aclr_n & wren_c;
    mem_rden    = aclr_n & rden_c;
    init_done   = (state_q == StRun);
    req0_ready  = gnt0;
    req1_ready  = gnt1;
    rsp0_valid  = tag_vld_q[TagDepth-1] & ~tag_id_q[TagDepth-1];
    rsp1_valid  = tag_vld_q[TagDepth-1] & tag_id_q[TagDepth-1];
    // Read data is broadcast; only rsp{i}_valid qualifies it.
    rsp0_q      = mem_q;
    rsp1_q      = mem_q;
  end

endmodule

// File: tb/tb_altsyncram_arbiter.sv
// Bench for altsyncram_arbiter: behavioural RAM, a spec-level reference model
// that predicts grants and read data, and a monitor that checks responses.
module tb_altsyncram_arbiter;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned BEW   = DW / 8;
  localparam int unsigned LAT   = 2;
  localparam int unsigned WORDS = 1 << AW;
  localparam logic [DW-1:0] INITV = 32'hA5A5A5A5;

  logic          clock0 = 1'b0;
  logic          aclr_n;
  logic          init_req;
  logic          init_done;
  logic          r0_valid, r0_we, r1_valid, r1_we;
  logic [AW-1:0] r0_adr, r1_adr;
  logic [BEW-1:0] r0_be, r1_be;
  logic [DW-1:0] r0_d, r1_d;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_q, rsp1_q;
  logic [AW-1:0] mem_address;
  logic          mem_wren, mem_rden;
  logic [BEW-1:0] mem_byteena;
  logic [DW-1:0] mem_data, mem_q;

  altsyncram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BEW), .RD_LATENCY(LAT), .INIT_VALUE(INITV)
  ) dut (
    .clock0(clock0), .aclr_n(aclr_n), .init_req(init_req), .init_done(init_done),
    .req0_valid(r0_valid), .req0_ready(req0_ready), .req0_we(r0_we), .req0_adr(r0_adr),
    .req0_be(r0_be), .req0_d(r0_d), .rsp0_valid(rsp0_valid), .rsp0_q(rsp0_q),
    .req1_valid(r1_valid), .req1_ready(req1_ready), .req1_we(r1_we), .req1_adr(r1_adr),
    .req1_be(r1_be), .req1_d(r1_d), .rsp1_valid(rsp1_valid), .rsp1_q(rsp1_q),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_byteena(mem_byteena), .mem_data(mem_data), .mem_q(mem_q)
  );

  always #5 clock0 = ~clock0;

  // Behavioural single-port RAM with optional output register.
  logic [DW-1:0] ram [WORDS];
  logic [DW-1:0] ram_q1 = '0;
  logic [DW-1:0] ram_q2 = '0;
  always @(posedge clock0) begin
    if (mem_wren) begin
      for (int b = 0; b < BEW; b++) begin
        if (mem_byteena[b]) ram[mem_address][b*8 +: 8] <= mem_data[b*8 +: 8];
      end
    end
    if (mem_rden) ram_q1 <= ram[mem_address];
    ram_q2 <= ram_q1;
  end
  assign mem_q = (LAT == 1) ? ram_q1 : ram_q2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clock0) cyc <= cyc + 1;

  // Reference model state.
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t          expq [2][$];
  logic [DW-1:0] shadow [WORDS];
  bit            m_init = 1'b1;
  int            m_cnt  = 0;
  int            m_prio = 0;
  bit            acc0   = 1'b0;
  bit            acc1   = 1'b0;

  // Model: predicts each cycle's port behaviour from the arbitration rules.
  always @(negedge clock0) begin
    if (!aclr_n) begin
      chk("rst_init_done", init_done, 0);
      chk("rst_ready", {req1_ready, req0_ready}, 0);
      chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
      chk("rst_mem_en", {mem_wren, mem_rden}, 0);
      chk("rst_mem_bus", {mem_address, mem_byteena, mem_data}, 0);
      chk("rst_rsp_q", rsp0_q, mem_q);
      expq[0].delete();
      expq[1].delete();
      m_init = 1'b1;
      m_cnt  = 0;
      m_prio = 0;
      acc0   = 1'b0;
      acc1   = 1'b0;
    end else if (m_init) begin
      chk("init_ready", {req1_ready, req0_ready}, 0);
      chk("init_done_low", init_done, 0);
      chk("init_en", {mem_wren, mem_rden}, 2'b10);
      chk("init_addr", mem_address, m_cnt);
      chk("init_be", mem_byteena, {BEW{1'b1}});
      chk("init_data", mem_data, INITV);
      shadow[m_cnt] = INITV;
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (init_req) m_cnt = 0;
      else if (m_cnt == WORDS - 1) begin
        m_init = 1'b0;
        m_cnt  = 0;
      end else m_cnt++;
    end else begin
      int g;
      logic we;
      logic [AW-1:0] a;
      logic [BEW-1:0] be;
      logic [DW-1:0] d;
      exp_t e;
      g = -1;
      if (r0_valid && r1_valid) begin
        g = m_prio;
        m_prio = (g == 0) ? 1 : 0;
      end else if (r0_valid) g = 0;
      else if (r1_valid) g = 1;
      chk("run_init_done", init_done, 1);
      chk("ready0", req0_ready, g == 0);
      chk("ready1", req1_ready, g == 1);
      if (g >= 0) begin
        we = (g == 0) ? r0_we : r1_we;
        a  = (g == 0) ? r0_adr : r1_adr;
        be = (g == 0) ? r0_be : r1_be;
        d  = (g == 0) ? r0_d : r1_d;
        chk("mem_en", {mem_wren, mem_rden}, {we, ~we});
        chk("mem_addr", mem_address, a);
        if (we) begin
          chk("mem_be", mem_byteena, be);
          chk("mem_data", mem_data, d);
          for (int b = 0; b < BEW; b++) begin
            if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
          end
        end else begin
          e.data = shadow[a];
          e.due  = cyc + LAT;
          expq[g].push_back(e);
        end
      end else begin
        chk("idle_en", {mem_wren, mem_rden}, 0);
      end
      acc0 = (g == 0);
      acc1 = (g == 1);
      if (init_req) begin
        m_init = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  // Monitor: pops expected read data whenever a response is presented.
  always @(negedge clock0) begin
    if (aclr_n) begin
      for (int i = 0; i < 2; i++) begin
        logic          rv;
        logic [DW-1:0] rq;
        exp_t          e;
        rv = (i == 0) ? rsp0_valid : rsp1_valid;
        rq = (i == 0) ? rsp0_q : rsp1_q;
        if (rv) begin
          if (expq[i].size() == 0) begin
            chk($sformatf("rsp%0d_unexpected", i), 1, 0);
          end else begin
            e = expq[i].pop_front();
            chk($sformatf("rsp%0d_data", i), rq, e.data);
            chk($sformatf("rsp%0d_cycle", i), cyc, e.due);
          end
        end else if (expq[i].size() != 0 && expq[i][0].due < cyc) begin
          e = expq[i].pop_front();
          chk($sformatf("rsp%0d_missing", i), 0, 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock0);
    #1;
  endtask

  task automatic idle();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    init_req = 1'b0;
  endtask

  task automatic set0(input logic we, input logic [AW-1:0] a, input logic [BEW-1:0] be,
                      input logic [DW-1:0] d);
    r0_valid = 1'b1; r0_we = we; r0_adr = a; r0_be = be; r0_d = d;
  endtask

  task automatic set1(input logic we, input logic [AW-1:0] a, input logic [BEW-1:0] be,
                      input logic [DW-1:0] d);
    r1_valid = 1'b1; r1_we = we; r1_adr = a; r1_be = be; r1_d = d;
  endtask

  // Release reset (already low) and check init_done rises in the 17th cycle.
  task automatic release_and_time_init();
    int k;
    aclr_n = 1'b1;
    k = 0;
    while (k < 40) begin
      @(negedge clock0);
      k++;
      if (init_done) break;
    end
    chk("init_done_cycle", k, WORDS + 1);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    aclr_n = 1'b0;
    idle();
    r0_we = 0; r0_adr = '0; r0_be = '0; r0_d = '0;
    r1_we = 0; r1_adr = '0; r1_be = '0; r1_d = '0;
    repeat (3) step();
    release_and_time_init();
    step();

    // Read of a cleared word.
    set0(1'b0, 4'd7, '0, '0); step(); idle(); repeat (3) step();

    // Partial write then read back.
    set0(1'b1, 4'd3, 4'b0011, 32'hDEADBEEF); step();
    set0(1'b0, 4'd3, '0, '0); step(); idle(); repeat (3) step();

    // Sustained conflict: grants alternate starting with requester 0.
    set0(1'b0, 4'd1, '0, '0);
    set1(1'b0, 4'd2, '0, '0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clock0);
      chk("conflict_grant1", req1_ready, k % 2);
      @(posedge clock0); #1;
    end
    idle(); repeat (4) step();

    // Back-to-back reads with pipelined returns.
    for (int a = 1; a <= 3; a++) begin
      set0(1'b0, a[AW-1:0], '0, '0); step();
    end
    idle(); repeat (4) step();

    // init_req right after a requester 1 read: response still drains.
    set1(1'b0, 4'd3, '0, '0); step();
    idle(); init_req = 1'b1; step();
    init_req = 1'b0;
    set0(1'b0, 4'd3, '0, '0);
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clock0);
      if (req0_ready) break;
      cnt++;
    end
    chk("reinit_ready_low_cycles", cnt, WORDS);
    @(posedge clock0); #1;
    idle(); repeat (4) step();

    // Reset with a read in flight.
    set0(1'b0, 4'd4, '0, '0); step();
    idle(); aclr_n = 1'b0;
    repeat (3) step();
    release_and_time_init();
    repeat (3) step();

    // Randomised traffic with occasional re-initialisation.
    for (int n = 0; n < 600; n++) begin
      init_req = ($urandom_range(0, 149) == 0);
      if (!r0_valid || acc0) begin
        r0_valid = ($urandom_range(0, 3) != 0);
        r0_we = $urandom_range(0, 1); r0_adr = AW'($urandom); r0_be = BEW'($urandom);
        r0_d = $urandom;
      end
      if (!r1_valid || acc1) begin
        r1_valid = ($urandom_range(0, 3) != 0);
        r1_we = $urandom_range(0, 1); r1_adr = AW'($urandom); r1_be = BEW'($urandom);
        r1_d = $urandom;
      end
      step();
    end
    idle();
    repeat (30) step();
    chk("drain_empty", expq[0].size() + expq[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/altsyncram_arbiter.md
# altsyncram_arbiter

Two-requester arbiter and initialisation sequencer for one port of an `altsyncram` instance in single-port or BIDIR mode. After reset it clears every word to a programmable value. It then shares the port between two requesters using valid/ready handshakes with round-robin priority. Read data is routed back to the issuing requester after the RAM's read latency. It sits between bus-side masters (e.g. CPU bridge, video fetch) and the RAM primitive.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word address width; words = 2**ADDR_WIDTH (must equal RAM `widthad_a`).
- `DATA_WIDTH`, 32: data width, multiple of 8.
- `BE_WIDTH`, DATA_WIDTH/8: byte-enable width.
- `RD_LATENCY`, 1: clocks from address sample to valid `mem_q`; 1 = `outdata_reg_a` "UNREGISTERED", 2 = "CLOCK0". Other values are illegal and must be flagged by an elaboration assertion.
- `INIT_VALUE`, 0: word written to every address during INIT.

Ports (`i` = 0, 1; requester 0 and requester 1 are identical):
- `clock0`  in  1  single clock; RAM `clock0` shares it.
- `aclr_n`  in  1  asynchronous, active-low reset.
- `init_req`  in  1  pulse; restart memory clear.
- `init_done`  out  1  high when the FSM is in RUN.
- `req{i}_valid`  in  1  request present.
- `req{i}_ready`  out  1  request accepted this cycle.
- `req{i}_we`  in  1  1 = write, 0 = read.
- `req{i}_adr`  in  ADDR_WIDTH  word address.
- `req{i}_be`  in  BE_WIDTH  byte enables (writes only).
- `req{i}_d`  in  DATA_WIDTH  write data.
- `rsp{i}_valid`  out  1  read data valid, one-cycle pulse.
- `rsp{i}_q`  out  DATA_WIDTH  read data.
- `mem_address`  out  ADDR_WIDTH  to RAM `address_a`.
- `mem_wren`  out  1  to RAM `wren_a`.
- `mem_rden`  out  1  to RAM `rden_a`.
- `mem_byteena`  out  BE_WIDTH  to RAM `byteena_a`.
- `mem_data`  out  DATA_WIDTH  to RAM `data_a`.
- `mem_q`  in  DATA_WIDTH  from RAM `q_a`.

## Operation
FSM states: INIT, RUN.

INIT:
- Reset enters INIT with `clr_cnt`=0.
- Each cycle drives `mem_address`=`clr_cnt`, `mem_wren`=1, `mem_byteena`=all ones, `mem_data`=INIT_VALUE, `mem_rden`=0, then increments `clr_cnt`.
- After writing address 2**ADDR_WIDTH-1, the FSM moves to RUN on the next edge; `clr_cnt` wraps to 0.
- `req{i}_ready`=0 throughout INIT.

RUN:
- Combinational grant. If only one valid is high, that requester wins. If both are high, the requester selected by `prio` wins.
- `prio` is a 1-bit register, reset 0, where 0 favours requester 0. On every two-way conflict `prio` moves to the loser; it is unchanged otherwise.
- `req{i}_ready` = grant{i}. The handshake completes when valid && ready.
- The winner's `adr`/`be`/`d` drive the mem_* outputs combinationally. `mem_wren`=we, `mem_rden`=!we.
- When there is no grant: `mem_wren`=0, `mem_rden`=0, address/data hold the last value (no toggling required).
- Throughput is one access per clock. No per-requester limit on outstanding reads.

Read return:
- Tag pipeline of depth RD_LATENCY; each stage holds {valid, id}.
- Stage 0 is loaded in the cycle a read handshake completes.
- When the last stage is valid: `rsp{id}_valid`=1 and `rsp{i}_q`=`mem_q` for both i (unqualified data).

`init_req` in RUN:
- Transition to INIT on the next edge, `clr_cnt`=0.
- Reads already in the tag pipeline still drain and respond.
- `init_req` while already in INIT restarts `clr_cnt` at 0.

Write-then-read to the same address on consecutive cycles returns the new data (RAM writes on the same edge). A read and a write cannot occur in the same cycle, so there is no RDW hazard.

## Timing
Reset values while `aclr_n`=0:
- `init_done`=0, `req{i}_ready`=0, `rsp{i}_valid`=0.
- `mem_wren`=0, `mem_rden`=0 (gated by reset).
- `mem_address`=0, `mem_byteena`=0, `mem_data`=0.
- `rsp{i}_q` follows `mem_q`.
- Tag pipeline cleared, `prio`=0, `clr_cnt`=0.

INIT duration:
- The first INIT write occurs in the first cycle after reset deassertion.
- INIT lasts exactly 2**ADDR_WIDTH cycles.
- `init_done` rises in the cycle after the final clear write.

Read latency:
- A read handshake in cycle N produces `rsp_valid` in cycle N+RD_LATENCY.

Reset asserted mid-operation:
- The tag pipeline is flushed and no responses are emitted.
- INIT restarts from 0.

## Test plan
- Reset, ADDR_WIDTH=4, INIT_VALUE=32'hA5A5A5A5 -> 16 consecutive writes to addresses 0..15; `init_done` high in cycle 17; a subsequent read of address 7 returns A5A5A5A5.
- Requester 0 writes 0xDEADBEEF to 3 with be=4'b0011, then reads 3 -> `rsp0_q`=0xA5A5BEEF, `rsp1_valid` never asserted.
- Both valid continuously for 6 cycles -> grants 0,1,0,1,0,1; `prio` ends at 0.
- Requester 0 reads addresses 1,2,3 back-to-back with RD_LATENCY=2 -> `rsp0_valid` high in cycles N+2..N+4 with data in address order.
- `init_req` pulsed one cycle after a requester 1 read -> `rsp1_valid` still pulses; ready drops for 16 cycles; memory is re-cleared.
- `aclr_n` low while reads are in flight -> no `rsp_valid`; INIT restarts from address 0 after release.
